// File: rtl/reg_file_wr_arbiter_if.sv
// Writeback bus between the two writeback requesters, the register file write
// port and the decode-stage hazard lookup.
// Optional feature macro: REG_WR_ARB_BYPASS_EN adds fwd_data_1/fwd_data_2.
interface reg_file_wr_arbiter_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              halt;
  logic              a_valid;
  logic              b_valid;
  logic [REG_AW-1:0] a_reg;
  logic [REG_AW-1:0] b_reg;
  logic [XLEN-1:0]   a_data;
  logic [XLEN-1:0]   b_data;
  logic              a_ready;
  logic              b_ready;
  logic              wr_en;
  logic [REG_AW-1:0] wr_reg;
  logic [XLEN-1:0]   wr_data;
  logic [REG_AW-1:0] rd_reg_1;
  logic [REG_AW-1:0] rd_reg_2;
  logic              hz_1;
  logic              hz_2;
`ifdef REG_WR_ARB_BYPASS_EN
  logic [XLEN-1:0]   fwd_data_1;
  logic [XLEN-1:0]   fwd_data_2;

  modport slave (
    input  halt, a_valid, b_valid, a_reg, b_reg, a_data, b_data, rd_reg_1, rd_reg_2,
    output a_ready, b_ready, wr_en, wr_reg, wr_data, hz_1, hz_2, fwd_data_1, fwd_data_2
  );
  modport master (
    output halt, a_valid, b_valid, a_reg, b_reg, a_data, b_data, rd_reg_1, rd_reg_2,
    input  a_ready, b_ready, wr_en, wr_reg, wr_data, hz_1, hz_2, fwd_data_1, fwd_data_2
  );
`else
  modport slave (
    input  halt, a_valid, b_valid, a_reg, b_reg, a_data, b_data, rd_reg_1, rd_reg_2,
    output a_ready, b_ready, wr_en, wr_reg, wr_data, hz_1, hz_2
  );
  modport master (
    output halt, a_valid, b_valid, a_reg, b_reg, a_data, b_data, rd_reg_1, rd_reg_2,
    input  a_ready, b_ready, wr_en, wr_reg, wr_data, hz_1, hz_2
  );
`endif
endinterface

// File: rtl/reg_file_wr_arbiter.sv
// Round-robin arbiter sharing the register file write port between the ALU
// writeback (port A) and the load writeback (port B), with a registered
// output stage and read-after-write hazard flags for decode.
// Optional feature macro: REG_WR_ARB_BYPASS_EN -- forward the in-flight write
// data to decode instead of flagging a hazard.
module reg_file_wr_arbiter #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  reg_file_wr_arbiter_if.slave  bus
);

  localparam logic LAST_A = 1'b0;
  localparam logic LAST_B = 1'b1;

  logic              last_grant_q, last_grant_d;
  logic              out_valid_q,  out_valid_d;
  logic [REG_AW-1:0] out_reg_q,    out_reg_d;
  logic [XLEN-1:0]   out_data_q,   out_data_d;
  logic              grant_a, grant_b;
  logic              hit_1, hit_2;

  // Round-robin grant; nothing is granted while in reset or halted
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!rst && !bus.halt) begin
      if (bus.a_valid && bus.b_valid) begin
        if (last_grant_q == LAST_B) grant_a = 1'b1;
        else                        grant_b = 1'b1;
      end else if (bus.a_valid) begin
        grant_a = 1'b1;
      end else if (bus.b_valid) begin
        grant_b = 1'b1;
      end
    end
  end

  // Next arbiter pointer and output stage contents; x0 writes are consumed silently
  always_comb begin
    last_grant_d = last_grant_q;
    out_valid_d  = 1'b0;
    out_reg_d    = out_reg_q;
    out_data_d   = out_data_q;
    if (grant_a) begin
      last_grant_d = LAST_A;
      out_valid_d  = (bus.a_reg != '0);
      out_reg_d    = bus.a_reg;
      out_data_d   = bus.a_data;
    end else if (grant_b) begin
      last_grant_d = LAST_B;
      out_valid_d  = (bus.b_reg != '0);
      out_reg_d    = bus.b_reg;
      out_data_d   = bus.b_data;
    end
  end

  // Arbiter pointer and output stage registers
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= LAST_B;
      out_valid_q  <= 1'b0;
      out_reg_q    <= '0;
      out_data_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      out_valid_q  <= out_valid_d;
      out_reg_q    <= out_reg_d;
      out_data_q   <= out_data_d;
    end
  end

  // Match decode read addresses against the write leaving the output stage
  always_comb begin
    hit_1 = out_valid_q && !rst && (out_reg_q == bus.rd_reg_1) && (bus.rd_reg_1 != '0);
    hit_2 = out_valid_q && !rst && (out_reg_q == bus.rd_reg_2) && (bus.rd_reg_2 != '0);
  end

  assign bus.a_ready = grant_a;
  assign bus.b_ready = grant_b;

  // A write sitting in the output stage is suppressed during the reset cycle
  // itself, so the register file never commits it.
  assign bus.wr_en   = out_valid_q && !rst;
  assign bus.wr_reg  = out_reg_q;
  assign bus.wr_data = out_data_q;

`ifdef REG_WR_ARB_BYPASS_EN
  assign bus.hz_1       = 1'b0;
  assign bus.hz_2       = 1'b0;
  assign bus.fwd_data_1 = hit_1 ? out_data_q : '0;
  assign bus.fwd_data_2 = hit_2 ? out_data_q : '0;
`else
  assign bus.hz_1 = hit_1;
  assign bus.hz_2 = hit_2;
`endif

endmodule

// File: tb/tb_reg_file_wr_arbiter.sv
// Directed bench for reg_file_wr_arbiter with a write scoreboard and a small
// register file model fed by the DUT write port.
module tb_reg_file_wr_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] rf [32];

  reg_file_wr_arbiter_if #(.XLEN(32), .REG_AW(5)) bus ();

  reg_file_wr_arbiter #(.XLEN(32), .REG_AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Register file model
  always @(posedge clk) begin
    if (bus.wr_en === 1'b1) rf[bus.wr_reg] <= bus.wr_data;
  end

  // Scoreboard: pop and compare writes, then push accepted non-x0 requests
  always @(negedge clk) begin
    wr_t e;
    if (rst === 1'b1) begin
      exp_q.delete();
    end else begin
      if (bus.wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_write", {27'd0, bus.wr_reg, bus.wr_data}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_write", {27'd0, bus.wr_reg, bus.wr_data}, {27'd0, e.r, e.d});
        end
      end
      if (bus.a_valid && bus.a_ready === 1'b1 && bus.a_reg != 5'd0)
        exp_q.push_back('{r: bus.a_reg, d: bus.a_data});
      if (bus.b_valid && bus.b_ready === 1'b1 && bus.b_reg != 5'd0)
        exp_q.push_back('{r: bus.b_reg, d: bus.b_data});
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    rst          = 1'b1;
    bus.halt     = 1'b0;
    bus.a_valid  = 1'b1;
    bus.b_valid  = 1'b1;
    bus.a_reg    = 5'd3;
    bus.a_data   = 32'h1111_1111;
    bus.b_reg    = 5'd4;
    bus.b_data   = 32'h2222_2222;
    bus.rd_reg_1 = 5'd0;
    bus.rd_reg_2 = 5'd0;

    // Reset held two cycles with both requesters valid
    for (int i = 0; i < 2; i++) begin
      tick();
      #1;
      chk("rst_a_ready", bus.a_ready, 0);
      chk("rst_b_ready", bus.b_ready, 0);
      chk("rst_wr_en",   bus.wr_en,   0);
      chk("rst_hz_1",    bus.hz_1,    0);
    end

    // Contention: A wins first after reset, then alternates
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("cont_a_ready", bus.a_ready, (i % 2 == 0));
      chk("cont_b_ready", bus.b_ready, (i % 2 == 1));
      chk("cont_wr_en",   bus.wr_en,   (i > 0));
      if (i > 0) chk("cont_wr_reg", bus.wr_reg, (i % 2 == 1) ? 3 : 4);
      tick();
    end
    bus.a_valid  = 1'b0;
    bus.b_valid  = 1'b0;
    bus.rd_reg_1 = 5'd4;
    bus.rd_reg_2 = 5'd3;
    #1;
    chk("cont_last_reg",  bus.wr_reg,  4);
    chk("cont_last_data", bus.wr_data, 32'h2222_2222);
`ifdef REG_WR_ARB_BYPASS_EN
    chk("cont_hz_1",  bus.hz_1,       0);
    chk("cont_fwd_1", bus.fwd_data_1, 32'h2222_2222);
    chk("cont_fwd_2", bus.fwd_data_2, 0);
`else
    chk("cont_hz_1", bus.hz_1, 1);
    chk("cont_hz_2", bus.hz_2, 0);
`endif

    // x0 write: accepted, never written, never a hazard
    tick();
    bus.a_valid  = 1'b1;
    bus.a_reg    = 5'd0;
    bus.a_data   = 32'hDEAD_BEEF;
    bus.rd_reg_1 = 5'd0;
    bus.rd_reg_2 = 5'd0;
    #1;
    chk("x0_a_ready", bus.a_ready, 1);
    tick();
    bus.a_valid = 1'b0;
    #1;
    chk("x0_wr_en",   bus.wr_en,   0);
    chk("x0_hz_1",    bus.hz_1,    0);
    chk("x0_wr_data", bus.wr_data, 32'hDEAD_BEEF);

    // Hazard on x7, no hazard on x8
    tick();
    bus.a_valid = 1'b1;
    bus.a_reg   = 5'd7;
    bus.a_data  = 32'hCAFE_F00D;
    #1;
    chk("hz_a_ready", bus.a_ready, 1);
    tick();
    bus.a_valid  = 1'b0;
    bus.rd_reg_1 = 5'd7;
    bus.rd_reg_2 = 5'd8;
    #1;
    chk("hz_wr_en", bus.wr_en, 1);
`ifdef REG_WR_ARB_BYPASS_EN
    chk("hz_hz_1",  bus.hz_1,       0);
    chk("hz_fwd_1", bus.fwd_data_1, 32'hCAFE_F00D);
    chk("hz_fwd_2", bus.fwd_data_2, 0);
`else
    chk("hz_hz_1", bus.hz_1, 1);
    chk("hz_hz_2", bus.hz_2, 0);
`endif
    tick();
    #1;
    chk("hz_window_closed", bus.hz_1, 0);
    bus.rd_reg_1 = 5'd0;
    bus.rd_reg_2 = 5'd0;

    // Halt: earlier write drains, no grants while halted
    tick();
    bus.a_valid = 1'b1;
    bus.a_reg   = 5'd9;
    bus.a_data  = 32'h0000_0099;
    #1;
    chk("halt_pre_a_ready", bus.a_ready, 1);
    tick();
    bus.halt    = 1'b1;
    bus.a_reg   = 5'd10;
    bus.a_data  = 32'h0000_00A0;
    bus.b_valid = 1'b1;
    bus.b_reg   = 5'd11;
    bus.b_data  = 32'h0000_00B0;
    #1;
    chk("halt_n_wr_en",   bus.wr_en,   1);
    chk("halt_n_wr_reg",  bus.wr_reg,  9);
    chk("halt_n_a_ready", bus.a_ready, 0);
    chk("halt_n_b_ready", bus.b_ready, 0);
    tick();
    #1;
    chk("halt_n1_wr_en",   bus.wr_en,   0);
    chk("halt_n1_a_ready", bus.a_ready, 0);
    chk("halt_n1_b_ready", bus.b_ready, 0);
    tick();
    bus.halt = 1'b0;
    #1;
    chk("unhalt_b_ready", bus.b_ready, 1);
    chk("unhalt_a_ready", bus.a_ready, 0);
    tick();
    bus.b_valid = 1'b0;
    #1;
    chk("unhalt2_a_ready", bus.a_ready, 1);
    chk("unhalt2_wr_reg",  bus.wr_reg,  11);
    tick();
    bus.a_valid = 1'b0;
    #1;
    chk("unhalt3_wr_reg", bus.wr_reg, 10);

    // Same destination from both ports: the loser's data lands last
    tick();
    bus.a_valid = 1'b1;
    bus.a_reg   = 5'd5;
    bus.a_data  = 32'h0000_0055;
    bus.b_valid = 1'b1;
    bus.b_reg   = 5'd5;
    bus.b_data  = 32'h0000_0066;
    #1;
    chk("same_b_ready", bus.b_ready, 1);
    tick();
    bus.b_valid = 1'b0;
    #1;
    chk("same_a_ready", bus.a_ready, 1);
    chk("same_first",   bus.wr_data, 32'h0000_0066);
    tick();
    bus.a_valid = 1'b0;
    #1;
    chk("same_second", bus.wr_data, 32'h0000_0055);
    tick();
    #1;
    chk("same_rf_x5", rf[5], 32'h0000_0055);

    // Reset while a write is in the output stage
    tick();
    bus.a_valid  = 1'b1;
    bus.a_reg    = 5'd12;
    bus.a_data   = 32'h0000_000C;
    bus.rd_reg_1 = 5'd12;
    #1;
    chk("rstmid_a_ready", bus.a_ready, 1);
    tick();
    bus.a_valid = 1'b0;
    rst         = 1'b1;
    #1;
    chk("rstmid_wr_en", bus.wr_en, 0);
    chk("rstmid_hz_1",  bus.hz_1,  0);
    tick();
    rst = 1'b0;
    #1;
    chk("rstmid_after_wr_en", bus.wr_en, 0);
    chk("rstmid_rf_x12",      rf[12],    0);
    chk("rf_x3",              rf[3],     32'h1111_1111);
    chk("rf_x4",              rf[4],     32'h2222_2222);
    chk("rf_x7",              rf[7],     32'hCAFE_F00D);
    chk("rf_x0",              rf[0],     0);
    tick();
    chk("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
